// File: rtl/srl_fifo_flow_pkg.sv
// Shared helpers for the srl_fifo_flow shift-register FIFO.
// Holds the count-width function and the err bit positions.
package srl_fifo_flow_pkg;

    localparam int unsigned ERR_OVF = 1;
    localparam int unsigned ERR_UDF = 0;

    // Occupancy ranges over 0..depth inclusive, so one extra code is needed.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/srl_fifo_flow_store.sv
// SRL-style storage for srl_fifo_flow: shift-in at entry 0, random-access read.
// Deliberately unreset so it maps onto shift-register primitives.
module srl_fifo_flow_store #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem_q[i] <= mem_q[i-1];
            end
            mem_q[0] <= din;
        end
    end

    assign dout = mem_q[addr];

endmodule

// File: rtl/srl_fifo_flow.sv
// Shift-register FIFO with ap_fifo-style handshakes, registered flags and occupancy count.
// Define SRL_FIFO_FLOW_ERRCHK_EN to enable sticky overflow/underflow attempt flags on err.
module srl_fifo_flow
    import srl_fifo_flow_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned DEPTH      = 4,
    parameter  int unsigned AF_MARGIN  = 1,
    localparam int unsigned CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [CNT_W-1:0]      count,
    output logic [1:0]            err
);

    localparam int unsigned    ADDR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_THR  = CNT_W'(DEPTH - AF_MARGIN);

    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_n_q, full_n_d;
    logic              af_n_q, af_n_d;
    logic              empty_n_q, empty_n_d;
    logic              push, pop;
    logic [ADDR_W-1:0] head_addr;

    always_comb begin
        push      = if_write & if_write_ce & full_n_q;
        pop       = if_read & if_read_ce & empty_n_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != DEPTH_C);
        af_n_d    = (count_d < AF_THR);
        // Oldest word sits at count-1; a simultaneous push shifts the next-oldest into that slot.
        head_addr = (count_q == '0) ? '0 : ADDR_W'(count_q - 1'b1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            full_n_q  <= 1'b1;
            af_n_q    <= 1'b1;
            empty_n_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            full_n_q  <= full_n_d;
            af_n_q    <= af_n_d;
            empty_n_q <= empty_n_d;
        end
    end

    srl_fifo_flow_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_store (
        .clk  (clk),
        .we   (push),
        .addr (head_addr),
        .din  (if_din),
        .dout (if_dout)
    );

    assign count            = count_q;
    assign if_full_n        = full_n_q;
    assign if_almost_full_n = af_n_q;
    assign if_empty_n       = empty_n_q;

`ifdef SRL_FIFO_FLOW_ERRCHK_EN
    logic [1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (if_write && if_write_ce && !full_n_q) begin
            err_d[ERR_OVF] = 1'b1;
        end
        if (if_read && if_read_ce && !empty_n_q) begin
            err_d[ERR_UDF] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_srl_fifo_flow.sv
// Directed self-checking bench for srl_fifo_flow (DEPTH=4, DATA_WIDTH=8, AF_MARGIN=1).
module tb_srl_fifo_flow;

    logic       clk = 1'b0;
    logic       reset;
    logic       if_write_ce, if_write, if_read_ce, if_read;
    logic [7:0] if_din;
    logic       if_full_n, if_almost_full_n, if_empty_n;
    logic [7:0] if_dout;
    logic [2:0] count;
    logic [1:0] err;

    int errors = 0;
    int checks = 0;

    srl_fifo_flow #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .AF_MARGIN  (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .if_write_ce      (if_write_ce),
        .if_write         (if_write),
        .if_din           (if_din),
        .if_full_n        (if_full_n),
        .if_almost_full_n (if_almost_full_n),
        .if_read_ce       (if_read_ce),
        .if_read          (if_read),
        .if_dout          (if_dout),
        .if_empty_n       (if_empty_n),
        .count            (count),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] c, input logic e, input logic f,
                             input logic af);
        chk({tag, "_count"}, 32'(count), 32'(c));
        chk({tag, "_empty_n"}, 32'(if_empty_n), 32'(e));
        chk({tag, "_full_n"}, 32'(if_full_n), 32'(f));
        chk({tag, "_af_n"}, 32'(if_almost_full_n), 32'(af));
    endtask

    logic [1:0] exp_err_udf, exp_err_both;

    initial begin
`ifdef SRL_FIFO_FLOW_ERRCHK_EN
        exp_err_udf  = 2'b01;
        exp_err_both = 2'b11;
`else
        exp_err_udf  = 2'b00;
        exp_err_both = 2'b00;
`endif
        reset = 1'b1;
        if_write_ce = 1'b0; if_write = 1'b0; if_din = 8'h00;
        if_read_ce = 1'b0;  if_read = 1'b0;
        #12;
        chk_state("rst", 3'd0, 1'b0, 1'b1, 1'b1);
        chk("rst_err", 32'(err), 32'h0);
        tick();
        reset = 1'b0;

        // Write request without clock-enable is ignored
        if_write = 1'b1; if_din = 8'h55;
        tick();
        chk_state("wce0", 3'd0, 1'b0, 1'b1, 1'b1);
        if_write = 1'b0;

        // Read while empty
        if_read = 1'b1; if_read_ce = 1'b1;
        tick();
        chk_state("udf", 3'd0, 1'b0, 1'b1, 1'b1);
        chk("udf_err", 32'(err), 32'(exp_err_udf));
        if_read = 1'b0;

        // Fill
        if_write = 1'b1; if_write_ce = 1'b1;
        if_din = 8'h11; tick();
        chk_state("fill1", 3'd1, 1'b1, 1'b1, 1'b1);
        chk("fill1_dout", 32'(if_dout), 32'h11);
        if_din = 8'h22; tick();
        chk_state("fill2", 3'd2, 1'b1, 1'b1, 1'b1);
        if_din = 8'h33; tick();
        chk_state("fill3", 3'd3, 1'b1, 1'b1, 1'b0);
        if_din = 8'h44; tick();
        chk_state("fill4", 3'd4, 1'b1, 1'b0, 1'b0);
        chk("fill4_dout", 32'(if_dout), 32'h11);

        // Write while full
        if_din = 8'h99; tick();
        chk_state("ovf", 3'd4, 1'b1, 1'b0, 1'b0);
        chk("ovf_dout", 32'(if_dout), 32'h11);
        chk("ovf_err", 32'(err), 32'(exp_err_both));
        if_write = 1'b0;

        // Read request without clock-enable is ignored
        if_read = 1'b1; if_read_ce = 1'b0;
        tick();
        chk_state("rce0", 3'd4, 1'b1, 1'b0, 1'b0);
        chk("rce0_dout", 32'(if_dout), 32'h11);

        // Drain
        if_read_ce = 1'b1;
        tick();
        chk_state("drain1", 3'd3, 1'b1, 1'b1, 1'b0);
        chk("drain1_dout", 32'(if_dout), 32'h22);
        tick();
        chk_state("drain2", 3'd2, 1'b1, 1'b1, 1'b1);
        chk("drain2_dout", 32'(if_dout), 32'h33);
        tick();
        chk_state("drain3", 3'd1, 1'b1, 1'b1, 1'b1);
        chk("drain3_dout", 32'(if_dout), 32'h44);
        tick();
        chk_state("drain4", 3'd0, 1'b0, 1'b1, 1'b1);
        if_read = 1'b0;

        // Simultaneous push and pop at count=2
        if_write = 1'b1;
        if_din = 8'hA0; tick();
        if_din = 8'hA1; tick();
        chk_state("sim_pre", 3'd2, 1'b1, 1'b1, 1'b1);
        chk("sim_pre_dout", 32'(if_dout), 32'hA0);
        if_din = 8'hA2; if_read = 1'b1;
        tick();
        chk_state("sim", 3'd2, 1'b1, 1'b1, 1'b1);
        chk("sim_dout", 32'(if_dout), 32'hA1);
        if_write = 1'b0;
        tick();
        chk("sim_pop1", 32'(if_dout), 32'hA2);
        chk("sim_pop1_count", 32'(count), 32'd1);
        tick();
        chk_state("sim_pop2", 3'd0, 1'b0, 1'b1, 1'b1);
        if_read = 1'b0;

        // Mid-stream asynchronous reset, checked before the next clock edge
        if_write = 1'b1; if_din = 8'hC0;
        tick();
        tick();
        if_write = 1'b0;
        chk("mid_pre_count", 32'(count), 32'd2);
        reset = 1'b1;
        #2;
        chk_state("mid_rst", 3'd0, 1'b0, 1'b1, 1'b1);
        chk("mid_rst_err", 32'(err), 32'h0);
        tick();
        reset = 1'b0;

        // Write ignored when full even with a pop in the same cycle
        if_write = 1'b1;
        if_din = 8'hB0; tick();
        if_din = 8'hB1; tick();
        if_din = 8'hB2; tick();
        if_din = 8'hB3; tick();
        chk_state("full_pre", 3'd4, 1'b1, 1'b0, 1'b0);
        if_din = 8'hBF; if_read = 1'b1;
        tick();
        chk_state("full_rw", 3'd3, 1'b1, 1'b1, 1'b0);
        chk("full_rw_dout", 32'(if_dout), 32'hB1);
        if_write = 1'b0;
        if_read = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
